multi_frame_buffer: RTL and testbench
=====================================

Name: multi_frame_buffer

Overview:
- Parametrised successor to the two-buffer BRAM manager. Provides NUM_BUFFERS (2..4) frame buffers between the ray marcher (writer) and vga_display (reader).
- The writer fills a back buffer and signals frame completion. The reader switches to the newest completed frame only at its own frame start.
- The result is tear-free double or triple buffering, with back-pressure when no buffer is free and frame drop/repeat statistics.

Parameters:
- WIDTH, 4, pixel data bits.
- DEPTH, 76800, pixels per buffer.
- ADDR_LEN, $clog2(DEPTH), pixel address bits.
- NUM_BUFFERS, 3, buffer count; legal range 2..4.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset. Asynchronous, active-low.
- write_valid_in  input  1  pixel write strobe.
- write_addr_in  input  ADDR_LEN  pixel address of the write.
- write_data_in  input  WIDTH  pixel value.
- write_frame_done_in  input  1  single-cycle pulse: the back buffer is complete.
- write_ready_out  output  1  a back buffer is available; writes are accepted.
- read_addr_in  input  ADDR_LEN  read address from the display.
- read_frame_start_in  input  1  single-cycle pulse at the display frame boundary.
- read_data_out  output  WIDTH  pixel data, 2-cycle latency.
- write_buf_out  output  2  index of the buffer being written.
- read_buf_out  output  2  index of the buffer being displayed.
- dropped_frames_out  output  CNT_WIDTH  completed frames overwritten before display (saturating).
- repeated_frames_out  output  CNT_WIDTH  frame starts with no new frame available (saturating).

Behaviour:
- Each buffer is in one of four states: FREE, WRITING, READY, DISPLAYING. At most one buffer is READY, exactly one is DISPLAYING, and at most one is WRITING.
- Reset (asynchronous, rst_n_in=0):
  - buffer 0 = WRITING; buffer NUM_BUFFERS-1 = DISPLAYING; all others FREE.
  - write_buf_out=0, read_buf_out=NUM_BUFFERS-1, write_ready_out=1, read_data_out=0, both counters=0.
  - The read pipeline is cleared.
- Write:
  - Accepted when write_valid_in && write_ready_out && write_addr_in<DEPTH. Stored into write_buf_out at the next edge.
  - Any other write is silently dropped.
- write_frame_done_in (ignored when write_ready_out=0):
  - The WRITING buffer becomes READY.
  - A previously READY buffer becomes FREE, and dropped_frames_out increments.
  - The lowest-index FREE buffer becomes WRITING, and write_buf_out updates next cycle.
  - If no buffer is FREE, write_ready_out=0 from the next cycle.
- A write in the same cycle as write_frame_done_in belongs to the finishing buffer.
- read_frame_start_in:
  - If a READY buffer exists, it becomes DISPLAYING and the old DISPLAYING buffer becomes FREE.
  - Otherwise the DISPLAYING buffer is unchanged and repeated_frames_out increments.
  - read_buf_out updates next cycle.
- Stalled writer: if a buffer freed by read_frame_start_in is the only FREE one, it becomes WRITING in that same update. write_ready_out returns to 1 one cycle after the pulse.
- Simultaneous done and start: the done transition is evaluated first, so the just-finished frame is displayed immediately (it counts as neither dropped nor repeated). Allocation then uses the post-start FREE set.
- Read pipeline:
  - Cycle t: read_addr_in is sampled with the current read_buf_out.
  - Cycle t+1: BRAM registered read.
  - Cycle t+2: read_data_out is valid.
  - The buffer index is carried through the pipeline, so addresses presented in the read_frame_start_in cycle still read the old buffer; from the following cycle they read the new one.
  - An address >= DEPTH returns 0.
- Read-during-write to the same buffer and address cannot occur, because the WRITING and DISPLAYING buffers are always distinct.
- Counters saturate at all-ones.
- Reset asserted mid-frame discards all frame state immediately. BRAM contents are not cleared.

Decomposition:
- Shared package / types.sv additions:
  - buf_state_t enum {FREE, WRITING, READY, DISPLAYING}.
  - `FB_MAX_BUFFERS=4.
  - Reuse `DISPLAY_WIDTH/`DISPLAY_HEIGHT/`ADDR_BITS for the defaults.
- Sub-module fb_bram: simple dual-port, one write port and one read port, WIDTH x DEPTH, registered output (1-cycle). Instantiated NUM_BUFFERS times via generate.
- The top level holds the buffer state machine, the index pipeline, the output mux and the counters.

Test Plan:
1. Reset; write addr 5 = 0xA (write_buf_out=0); done; start; read addr 5.
   -> read_buf_out=0 one cycle after start; read_data_out=0xA two cycles after the address.
2. NUM_BUFFERS=3; two frames complete (done, done) with no start; then start.
   -> dropped_frames_out=1; read_buf_out = buffer of the second frame; write_ready_out stays 1.
3. NUM_BUFFERS=2; done without start.
   -> write_ready_out=0 next cycle; writes to addr 7 are ignored. Then start.
   -> write_ready_out=1 a cycle later; write_buf_out=1; read_buf_out=0.
4. done and start in the same cycle (after reset).
   -> read_buf_out=0; repeated_frames_out=0; dropped_frames_out=0; write_buf_out=1 (NUM_BUFFERS=3).
5. Start with no READY buffer, three times.
   -> read_buf_out unchanged; repeated_frames_out=3. A read spanning the start cycle returns old-buffer data for the address presented in the start cycle.
6. Assert rst_n_in low asynchronously mid-write, between clock edges.
   -> outputs take reset values immediately: write_buf_out=0, read_buf_out=NUM_BUFFERS-1, counters 0, read_data_out=0. Writes resume after release.

Source files
------------

// File: rtl/multi_frame_buffer_pkg.sv
// Shared types and constants for the multi-buffer frame store.
package multi_frame_buffer_pkg;

  localparam int unsigned DISPLAY_WIDTH    = 320;
  localparam int unsigned DISPLAY_HEIGHT   = 240;
  localparam int unsigned FB_DEPTH_DEFAULT = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int unsigned FB_MAX_BUFFERS   = 4;
  localparam int unsigned BUF_IDX_W        = $clog2(FB_MAX_BUFFERS);

  typedef logic [BUF_IDX_W-1:0] buf_idx_t;

  typedef enum logic [1:0] {
    BUF_FREE       = 2'd0,
    BUF_WRITING    = 2'd1,
    BUF_READY      = 2'd2,
    BUF_DISPLAYING = 2'd3
  } buf_state_t;

endpackage

// File: rtl/multi_frame_buffer_bram.sv
// Simple dual-port block RAM with one-cycle registered read.
//   clk_i            : clock
//   we_i/waddr_i/wdata_i : write port
//   raddr_i          : read address, sampled every cycle
//   rdata_o          : read data, one cycle after raddr_i
module multi_frame_buffer_bram #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 76800,
  parameter int unsigned ADDR_LEN = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [ADDR_LEN-1:0] waddr_i,
  input  logic [WIDTH-1:0]    wdata_i,
  input  logic [ADDR_LEN-1:0] raddr_i,
  output logic [WIDTH-1:0]    rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i && (32'(waddr_i) < DEPTH)) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (32'(raddr_i) < DEPTH) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multi_frame_buffer.sv
// N-way frame buffer manager between a pixel writer and a display reader.
// The writer fills a back buffer and pulses frame-done; the reader switches
// to the newest completed frame only at its own frame start.
//   clk_in, rst_n_in           : clock, async active-low reset
//   write_*_in                 : pixel write port and frame-done pulse
//   write_ready_out            : a back buffer is allocated, writes accepted
//   read_addr_in               : display read address
//   read_frame_start_in        : display frame boundary pulse
//   read_data_out              : pixel data, two cycles after read_addr_in
//   write_buf_out/read_buf_out : current back / front buffer indices
//   dropped/repeated_frames_out: saturating frame statistics
module multi_frame_buffer
  import multi_frame_buffer_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DEPTH       = FB_DEPTH_DEFAULT,
  parameter int unsigned ADDR_LEN    = $clog2(DEPTH),
  parameter int unsigned NUM_BUFFERS = 3,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 write_valid_in,
  input  logic [ADDR_LEN-1:0]  write_addr_in,
  input  logic [WIDTH-1:0]     write_data_in,
  input  logic                 write_frame_done_in,
  output logic                 write_ready_out,
  input  logic [ADDR_LEN-1:0]  read_addr_in,
  input  logic                 read_frame_start_in,
  output logic [WIDTH-1:0]     read_data_out,
  output logic [1:0]           write_buf_out,
  output logic [1:0]           read_buf_out,
  output logic [CNT_WIDTH-1:0] dropped_frames_out,
  output logic [CNT_WIDTH-1:0] repeated_frames_out
);

  buf_state_t st_q [NUM_BUFFERS];
  buf_state_t st_d [NUM_BUFFERS];

  buf_idx_t             write_buf_q, write_buf_d;
  buf_idx_t             read_buf_q, read_buf_d;
  logic                 write_ready_q, write_ready_d;
  logic [CNT_WIDTH-1:0] dropped_q, repeated_q;
  logic                 drop_inc, rep_inc;
  logic                 done_acc;
  logic                 have_ready, have_writing, alloc_done;
  logic                 wr_en;

  buf_idx_t             rd_buf_p1_q;
  logic                 rd_oob_p1_q;
  logic [WIDTH-1:0]     read_data_q;
  logic [WIDTH-1:0]     rd_mux;
  logic [WIDTH-1:0]     bank_rdata [NUM_BUFFERS];

  assign done_acc = write_frame_done_in && write_ready_q;
  assign wr_en    = write_valid_in && write_ready_q && (32'(write_addr_in) < DEPTH);

  // Buffer ownership: done first, then start, then back-buffer allocation.
  always_comb begin
    st_d          = st_q;
    drop_inc      = 1'b0;
    rep_inc       = 1'b0;
    have_ready    = 1'b0;
    have_writing  = 1'b0;
    alloc_done    = 1'b0;
    write_ready_d = 1'b0;
    write_buf_d   = write_buf_q;
    read_buf_d    = read_buf_q;

    if (done_acc) begin
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
        if (st_d[i] == BUF_READY) begin
          st_d[i]  = BUF_FREE;
          drop_inc = 1'b1;
        end
      end
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
        if (st_d[i] == BUF_WRITING) st_d[i] = BUF_READY;
      end
    end

    if (read_frame_start_in) begin
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
        if (st_d[i] == BUF_READY) have_ready = 1'b1;
      end
      if (have_ready) begin
        for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
          if (st_d[i] == BUF_DISPLAYING) st_d[i] = BUF_FREE;
          else if (st_d[i] == BUF_READY) st_d[i] = BUF_DISPLAYING;
        end
      end else begin
        rep_inc = 1'b1;
      end
    end

    for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
      if (st_d[i] == BUF_WRITING) have_writing = 1'b1;
    end
    // Lowest-index free buffer becomes the new back buffer.
    if (!have_writing) begin
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
        if (!alloc_done && (st_d[i] == BUF_FREE)) begin
          st_d[i]    = BUF_WRITING;
          alloc_done = 1'b1;
        end
      end
    end

    for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
      if (st_d[i] == BUF_WRITING) begin
        write_ready_d = 1'b1;
        write_buf_d   = buf_idx_t'(i);
      end
      if (st_d[i] == BUF_DISPLAYING) read_buf_d = buf_idx_t'(i);
    end
  end

  // Ownership state, indices and statistics.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
        if (i == 0)                    st_q[i] <= BUF_WRITING;
        else if (i == NUM_BUFFERS - 1) st_q[i] <= BUF_DISPLAYING;
        else                           st_q[i] <= BUF_FREE;
      end
      write_buf_q   <= '0;
      read_buf_q    <= buf_idx_t'(NUM_BUFFERS - 1);
      write_ready_q <= 1'b1;
      dropped_q     <= '0;
      repeated_q    <= '0;
    end else begin
      st_q          <= st_d;
      write_buf_q   <= write_buf_d;
      read_buf_q    <= read_buf_d;
      write_ready_q <= write_ready_d;
      if (drop_inc && (dropped_q != '1)) dropped_q <= dropped_q + CNT_WIDTH'(1);
      if (rep_inc && (repeated_q != '1)) repeated_q <= repeated_q + CNT_WIDTH'(1);
    end
  end

  // One RAM per buffer; only the back buffer sees write enables.
  for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_bank
    multi_frame_buffer_bram #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ADDR_LEN(ADDR_LEN)
    ) u_bram (
      .clk_i  (clk_in),
      .we_i   (wr_en && (write_buf_q == buf_idx_t'(g))),
      .waddr_i(write_addr_in),
      .wdata_i(write_data_in),
      .raddr_i(read_addr_in),
      .rdata_o(bank_rdata[g])
    );
  end

  // Select the bank that was displayed when the address was presented.
  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_BUFFERS; i++) begin
      if (rd_buf_p1_q == buf_idx_t'(i)) rd_mux = bank_rdata[i];
    end
  end

  // Buffer index and range flag travel alongside the RAM read.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_buf_p1_q <= '0;
      rd_oob_p1_q <= 1'b1;
      read_data_q <= '0;
    end else begin
      rd_buf_p1_q <= read_buf_q;
      rd_oob_p1_q <= (32'(read_addr_in) >= DEPTH);
      read_data_q <= rd_oob_p1_q ? '0 : rd_mux;
    end
  end

  assign write_ready_out     = write_ready_q;
  assign write_buf_out       = write_buf_q;
  assign read_buf_out        = read_buf_q;
  assign read_data_out       = read_data_q;
  assign dropped_frames_out  = dropped_q;
  assign repeated_frames_out = repeated_q;

endmodule

// File: tb/tb_multi_frame_buffer.sv
// Directed bench: DUT a is triple-buffered, DUT b is double-buffered with
// 2-bit counters so saturation is reachable.
module tb_multi_frame_buffer;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 100;
  localparam int unsigned AL = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          a_wv = 0, a_done = 0, a_start = 0;
  logic [AL-1:0] a_wa = '0, a_ra = '0;
  logic [W-1:0]  a_wd = '0;
  logic          a_ready;
  logic [W-1:0]  a_rd;
  logic [1:0]    a_wb, a_rb;
  logic [15:0]   a_drop, a_rep;

  logic          b_wv = 0, b_done = 0, b_start = 0;
  logic [AL-1:0] b_wa = '0, b_ra = '0;
  logic [W-1:0]  b_wd = '0;
  logic          b_ready;
  logic [W-1:0]  b_rd;
  logic [1:0]    b_wb, b_rb;
  logic [1:0]    b_drop, b_rep;

  int checks = 0;
  int errors = 0;

  multi_frame_buffer #(.WIDTH(W), .DEPTH(D), .NUM_BUFFERS(3), .CNT_WIDTH(16)) u_a (
    .clk_in(clk), .rst_n_in(rst_n),
    .write_valid_in(a_wv), .write_addr_in(a_wa), .write_data_in(a_wd),
    .write_frame_done_in(a_done), .write_ready_out(a_ready),
    .read_addr_in(a_ra), .read_frame_start_in(a_start), .read_data_out(a_rd),
    .write_buf_out(a_wb), .read_buf_out(a_rb),
    .dropped_frames_out(a_drop), .repeated_frames_out(a_rep)
  );

  multi_frame_buffer #(.WIDTH(W), .DEPTH(D), .NUM_BUFFERS(2), .CNT_WIDTH(2)) u_b (
    .clk_in(clk), .rst_n_in(rst_n),
    .write_valid_in(b_wv), .write_addr_in(b_wa), .write_data_in(b_wd),
    .write_frame_done_in(b_done), .write_ready_out(b_ready),
    .read_addr_in(b_ra), .read_frame_start_in(b_start), .read_data_out(b_rd),
    .write_buf_out(b_wb), .read_buf_out(b_rb),
    .dropped_frames_out(b_drop), .repeated_frames_out(b_rep)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset values
    tick(); tick();
    chk("rst_a_wb", 32'(a_wb), 0);
    chk("rst_a_rb", 32'(a_rb), 2);
    chk("rst_a_ready", 32'(a_ready), 1);
    chk("rst_a_rd", 32'(a_rd), 0);
    chk("rst_a_drop", 32'(a_drop), 0);
    chk("rst_a_rep", 32'(a_rep), 0);
    chk("rst_b_rb", 32'(b_rb), 1);
    rst_n = 1'b1;

    // Basic write / done / start / read
    a_wv = 1; a_wa = 7'd5; a_wd = 4'hA; tick();
    a_wv = 0; a_done = 1; tick();
    chk("t1_wb_after_done", 32'(a_wb), 1);
    a_done = 0; a_start = 1; tick();
    chk("t1_rb", 32'(a_rb), 0);
    a_start = 0; a_ra = 7'd5; tick(); tick();
    chk("t1_rd", 32'(a_rd), 32'hA);
    chk("t1_rep", 32'(a_rep), 0);
    chk("t1_drop", 32'(a_drop), 0);

    // Second frame into buffer 1, including last address and an out-of-range write
    a_wv = 1; a_wa = 7'd5; a_wd = 4'h3; tick();
    a_wa = 7'd99; a_wd = 4'h6; tick();
    a_wa = 7'd100; a_wd = 4'hF; tick();
    a_wv = 0; a_done = 1; tick();
    chk("t5_wb", 32'(a_wb), 2);
    a_done = 0; a_start = 1; a_ra = 7'd5; tick();
    chk("t5_rb", 32'(a_rb), 1);
    a_start = 0; tick();
    chk("t5_span_old", 32'(a_rd), 32'hA);
    a_ra = 7'd99; tick();
    chk("t5_span_new", 32'(a_rd), 32'h3);
    a_ra = 7'd100; tick();
    chk("t5_last_addr", 32'(a_rd), 32'h6);
    tick();
    chk("t5_oob_read", 32'(a_rd), 0);

    // Three starts with nothing ready
    for (int k = 0; k < 3; k++) begin
      a_start = 1; tick();
      a_start = 0; tick();
    end
    chk("t5_rep3", 32'(a_rep), 3);
    chk("t5_rb_held", 32'(a_rb), 1);

    // Two completed frames before a start: first is dropped
    a_done = 1; tick();
    chk("t2_wb1", 32'(a_wb), 0);
    tick();
    chk("t2_wb2", 32'(a_wb), 2);
    chk("t2_drop", 32'(a_drop), 1);
    chk("t2_ready", 32'(a_ready), 1);
    a_done = 0; a_start = 1; tick();
    chk("t2_rb", 32'(a_rb), 0);
    a_start = 0; a_ra = 7'd5; tick(); tick();
    chk("t2_rd", 32'(a_rd), 32'hA);

    // Double buffer stall
    b_wv = 1; b_wa = 7'd7; b_wd = 4'h4; tick();
    b_wv = 0; b_done = 1; tick();
    chk("t3_ready_low", 32'(b_ready), 0);
    chk("t3_wb_held", 32'(b_wb), 0);
    b_wv = 1; b_wd = 4'hC; tick();
    chk("t3_done_ignored", 32'(b_drop), 0);
    b_wv = 0; b_done = 0; b_start = 1; tick();
    chk("t3_ready_back", 32'(b_ready), 1);
    chk("t3_wb", 32'(b_wb), 1);
    chk("t3_rb", 32'(b_rb), 0);
    b_start = 0; b_ra = 7'd7; tick(); tick();
    chk("t3_stalled_write_dropped", 32'(b_rd), 32'h4);
    for (int k = 0; k < 4; k++) begin
      b_start = 1; tick();
      b_start = 0; tick();
    end
    chk("sat_rep", 32'(b_rep), 3);

    // Asynchronous reset mid-write
    a_wv = 1; a_wa = 7'd10; a_wd = 4'h5;
    #3 rst_n = 1'b0;
    #1;
    chk("t6_wb", 32'(a_wb), 0);
    chk("t6_rb", 32'(a_rb), 2);
    chk("t6_drop", 32'(a_drop), 0);
    chk("t6_rep", 32'(a_rep), 0);
    chk("t6_rd", 32'(a_rd), 0);
    chk("t6_b_rb", 32'(b_rb), 1);
    chk("t6_b_rep", 32'(b_rep), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Done and start together, with a write in the finishing cycle
    a_wa = 7'd11; a_wd = 4'h9; a_done = 1; a_start = 1; tick();
    chk("t4_rb", 32'(a_rb), 0);
    chk("t4_wb", 32'(a_wb), 1);
    chk("t4_rep", 32'(a_rep), 0);
    chk("t4_drop", 32'(a_drop), 0);
    a_wv = 0; a_done = 0; a_start = 0; a_ra = 7'd10; tick();
    a_ra = 7'd11; tick();
    chk("t6_write_resumed", 32'(a_rd), 32'h5);
    tick();
    chk("t4_write_with_done", 32'(a_rd), 32'h9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
